// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter driving the crossbar mux select codes.
// Each slave is owned by at most one master until ack or request drop.
module cross_bar_arbiter #(
  parameter int unsigned MASTER_N = 4,
  parameter int unsigned SLAVE_N  = 4,
  parameter int unsigned ADDR_W   = 32,
  localparam int unsigned SEL_W   = $clog2(SLAVE_N),
  localparam int unsigned MNUM_W  = $clog2(MASTER_N + 1),
  localparam int unsigned SNUM_W  = $clog2(SLAVE_N + 1)
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic [MASTER_N:1]                  master_req,
  input  logic [MASTER_N:1][ADDR_W-1:0]      master_addr,
  input  logic [SLAVE_N:1]                   slave_ack,
  output logic [SLAVE_N:1][MNUM_W-1:0]       slave_mux,
  output logic [MASTER_N:1][SNUM_W-1:0]      master_mux
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                         state_q [SLAVE_N:1];
  state_e                         state_d [SLAVE_N:1];
  logic [SLAVE_N:1][MNUM_W-1:0]   slave_mux_q, slave_mux_d;
  logic [SLAVE_N:1][MNUM_W-1:0]   last_q, last_d;
  logic [MASTER_N:1][SNUM_W-1:0]  master_mux_q, master_mux_d;

  logic [SNUM_W-1:0]              target [MASTER_N:1];
  logic [MASTER_N:1]              cand   [SLAVE_N:1];
  logic [MNUM_W-1:0]              win    [SLAVE_N:1];

  // First set bit of cand scanning last+1, last+2, ... with wrap; 0 if none.
  function automatic logic [MNUM_W-1:0] rr_pick(input logic [MNUM_W-1:0] last,
                                                input logic [MASTER_N:1] c);
    logic [MNUM_W-1:0] w;
    int idx;
    w = '0;
    for (int k = MASTER_N; k >= 1; k--) begin
      idx = ((int'(last) + k - 1) % MASTER_N) + 1;
      if (c[idx]) w = MNUM_W'(idx);
    end
    return w;
  endfunction

  // Address decode and per-slave candidate sets
  always_comb begin
    for (int m = 1; m <= MASTER_N; m++) begin
      target[m] = SNUM_W'(master_addr[m][ADDR_W-1 -: SEL_W]) + SNUM_W'(1);
    end
    for (int s = 1; s <= SLAVE_N; s++) begin
      for (int m = 1; m <= MASTER_N; m++) begin
        cand[s][m] = master_req[m] && (target[m] == SNUM_W'(s));
      end
    end
  end

  always_comb begin
    for (int s = 1; s <= SLAVE_N; s++) begin
      win[s] = rr_pick(last_q[s], cand[s]);
    end
  end

  // Per-slave IDLE/BUSY next-state logic
  always_comb begin
    for (int s = 1; s <= SLAVE_N; s++) begin
      state_d[s]     = state_q[s];
      slave_mux_d[s] = slave_mux_q[s];
      last_d[s]      = last_q[s];
      unique case (state_q[s])
        ST_IDLE: begin
          if (win[s] != '0) begin
            state_d[s]     = ST_BUSY;
            slave_mux_d[s] = win[s];
            last_d[s]      = win[s];
          end
        end
        ST_BUSY: begin
          if (slave_ack[s] || !master_req[slave_mux_q[s]]) begin
            state_d[s]     = ST_IDLE;
            slave_mux_d[s] = '0;
          end
        end
        default: begin
          state_d[s]     = ST_IDLE;
          slave_mux_d[s] = '0;
        end
      endcase
    end
  end

  // Reverse map; descending scan lets the lowest matching slave win
  always_comb begin
    for (int m = 1; m <= MASTER_N; m++) begin
      master_mux_d[m] = '0;
      for (int s = SLAVE_N; s >= 1; s--) begin
        if (slave_mux_d[s] == MNUM_W'(m)) master_mux_d[m] = SNUM_W'(s);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int s = 1; s <= SLAVE_N; s++) begin
        state_q[s]     <= ST_IDLE;
        slave_mux_q[s] <= '0;
        last_q[s]      <= MNUM_W'(MASTER_N);
      end
      master_mux_q <= '0;
    end else begin
      for (int s = 1; s <= SLAVE_N; s++) begin
        state_q[s]     <= state_d[s];
        slave_mux_q[s] <= slave_mux_d[s];
        last_q[s]      <= last_d[s];
      end
      master_mux_q <= master_mux_d;
    end
  end

  assign slave_mux  = slave_mux_q;
  assign master_mux = master_mux_q;

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Scoreboard bench for cross_bar_arbiter: directed stimulus pushes expected
// mux codes per cycle, a negedge monitor pops and compares.
module tb_cross_bar_arbiter;

  logic              clk;
  logic              aresetn;
  logic [4:1]        master_req;
  logic [4:1][31:0]  master_addr;
  logic [4:1]        slave_ack;
  logic [4:1][2:0]   slave_mux;
  logic [4:1][2:0]   master_mux;

  cross_bar_arbiter dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .master_req  (master_req),
    .master_addr (master_addr),
    .slave_ack   (slave_ack),
    .slave_mux   (slave_mux),
    .master_mux  (master_mux)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] exp_s_q [$];
  logic [11:0] exp_m_q [$];
  string       name_q  [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Pack four codes as {x4,x3,x2,x1}
  function automatic logic [11:0] pk(input int a4, input int a3, input int a2, input int a1);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1)};
  endfunction

  // Base address of slave s (top two address bits select the slave)
  function automatic logic [31:0] sa(input int s);
    return {2'(s - 1), 30'h0};
  endfunction

  task automatic push(input logic [11:0] es, input logic [11:0] em, input string nm);
    exp_s_q.push_back(es);
    exp_m_q.push_back(em);
    name_q.push_back(nm);
  endtask

  // Advance one edge, then record what the outputs must show after it
  task automatic cyc(input logic [11:0] es, input logic [11:0] em, input string nm);
    @(posedge clk);
    #1;
    push(es, em, nm);
  endtask

  always @(negedge clk) begin
    if (exp_s_q.size() > 0) begin
      logic [11:0] es, em;
      string nm;
      es = exp_s_q.pop_front();
      em = exp_m_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (slave_mux !== es) begin
        n_fail++;
        $display("FAIL %s slave_mux: got %h expected %h", nm, slave_mux, es);
      end
      n_checks++;
      if (master_mux !== em) begin
        n_fail++;
        $display("FAIL %s master_mux: got %h expected %h", nm, master_mux, em);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn     = 1'b0;
    master_req  = '0;
    master_addr = '0;
    slave_ack   = '0;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "reset");
    aresetn = 1'b1;

    // Single request M1 -> S2, ack three cycles after grant
    master_req     = 4'b0001;
    master_addr[1] = sa(2);
    cyc(pk(0,0,1,0), pk(0,0,0,2), "single_grant");
    cyc(pk(0,0,1,0), pk(0,0,0,2), "single_hold1");
    cyc(pk(0,0,1,0), pk(0,0,0,2), "single_hold2");
    slave_ack = 4'b0010;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "single_release");
    slave_ack  = '0;
    master_req = '0;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "single_idle");

    // Contention M1,M2,M3 -> S1, each acked one cycle after grant
    master_addr[1] = sa(1);
    master_addr[2] = sa(1);
    master_addr[3] = sa(1);
    master_req     = 4'b0111;
    cyc(pk(0,0,0,1), pk(0,0,0,1), "cont_g1");
    slave_ack = 4'b0001;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "cont_gap1");
    slave_ack = '0;
    cyc(pk(0,0,0,2), pk(0,0,1,0), "cont_g2");
    slave_ack = 4'b0001;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "cont_gap2");
    slave_ack = '0;
    cyc(pk(0,0,0,3), pk(0,1,0,0), "cont_g3");
    slave_ack = 4'b0001;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "cont_gap3");
    slave_ack = '0;
    cyc(pk(0,0,0,1), pk(0,0,0,1), "cont_g4_wrap");
    slave_ack  = 4'b0001;
    master_req = '0;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "cont_end");
    slave_ack = '0;

    // Parallel grants to four distinct slaves
    for (int m = 1; m <= 4; m++) master_addr[m] = sa(m);
    master_req = 4'b1111;
    cyc(pk(4,3,2,1), pk(4,3,2,1), "parallel_grant");
    slave_ack = 4'b1111;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "parallel_release");
    slave_ack  = '0;
    master_req = '0;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "parallel_idle");

    // Abort: M2 owns S3 and drops; waiting M4 then wins S3
    master_addr[2] = sa(3);
    master_addr[4] = sa(3);
    master_req     = 4'b0010;
    cyc(pk(0,2,0,0), pk(0,0,3,0), "abort_grant");
    master_req = 4'b1000;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "abort_release");
    cyc(pk(0,4,0,0), pk(3,0,0,0), "abort_next");
    slave_ack  = 4'b0100;
    master_req = '0;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "abort_end");
    slave_ack = '0;

    // Owner of S4 moves its address to busy S1's range; grant holds
    master_addr[1] = sa(1);
    master_addr[3] = sa(4);
    master_req     = 4'b0101;
    cyc(pk(3,0,0,1), pk(0,4,0,1), "addr_grant");
    master_addr[3] = sa(1);
    cyc(pk(3,0,0,1), pk(0,4,0,1), "addr_hold1");
    cyc(pk(3,0,0,1), pk(0,4,0,1), "addr_hold2");
    slave_ack = 4'b1000;
    cyc(pk(0,0,0,1), pk(0,0,0,1), "addr_release");
    slave_ack = '0;
    cyc(pk(0,0,0,1), pk(0,0,0,1), "addr_no_regrant");

    // Reset with three grants active, then pointer restart
    master_addr[2] = sa(2);
    master_addr[3] = sa(3);
    master_req     = 4'b0111;
    cyc(pk(0,3,2,1), pk(0,3,2,1), "pre_reset_grants");
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    push(pk(0,0,0,0), pk(0,0,0,0), "reset_immediate");
    master_addr[1] = sa(1);
    master_addr[4] = sa(1);
    master_req     = 4'b1001;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "reset_held");
    aresetn = 1'b1;
    cyc(pk(0,0,0,1), pk(0,0,0,1), "post_reset_m1_first");
    slave_ack = 4'b0001;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "post_reset_release");
    slave_ack = '0;
    cyc(pk(0,0,0,4), pk(1,0,0,0), "post_reset_m4");
    slave_ack  = 4'b0001;
    master_req = '0;
    cyc(pk(0,0,0,0), pk(0,0,0,0), "final_idle");
    slave_ack = '0;

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_s_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_s_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
